// File: rtl/data_path_if.sv
// Control, memory-data and observation signals of the single-bus datapath.
// The controller side drives load/drive strobes; the datapath returns bus and register views.
interface data_path_if;
   logic [31:0] Mdatain;
   logic        PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, Rin;
   logic        PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Csignout;
   logic        Gra, Grb, Grc;
   logic        ADD, IncPC, Read, MD_read;
   logic [31:0] bus_out, mar_out, ir_out, pc_out;

   modport master (
      output Mdatain, PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, Rin,
      output PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Csignout,
      output Gra, Grb, Grc, ADD, IncPC, Read, MD_read,
      input  bus_out, mar_out, ir_out, pc_out
   );

   modport slave (
      input  Mdatain, PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, Rin,
      input  PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Csignout,
      input  Gra, Grb, Grc, ADD, IncPC, Read, MD_read,
      output bus_out, mar_out, ir_out, pc_out
   );
endinterface

// File: rtl/data_path.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR/Y/Z and a small ALU on one shared bus.
// Bus is combinational; every register load lands one clock after its enable. No backpressure.
module data_path (
   input  logic     clock,
   input  logic     clear,
   data_path_if.slave bus_if
);
   logic [31:0] r_q [16];
   logic [31:0] r_d [16];
   logic [31:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
   logic [63:0] z_q, z_d;

   logic [3:0]  ra, rb, rc, reg_idx;
   logic [31:0] sel_reg, c_sext, bus;
   logic [32:0] sum;
   logic [63:0] alu_res;

   always_comb begin
      ra      = ir_q[26:23];
      rb      = ir_q[22:19];
      rc      = ir_q[18:15];
      reg_idx = 4'd0;
      if (bus_if.Gra)      reg_idx = ra;
      else if (bus_if.Grb) reg_idx = rb;
      else if (bus_if.Grc) reg_idx = rc;
      sel_reg = r_q[reg_idx];
      c_sext  = {{13{ir_q[18]}}, ir_q[18:0]};

      // Rout exposes R0 as stored; BAout treats R0 as a zero base.
      bus = 32'h0;
      if (bus_if.PCout)         bus = pc_q;
      else if (bus_if.MDRout)   bus = mdr_q;
      else if (bus_if.Zlowout)  bus = z_q[31:0];
      else if (bus_if.Zhighout) bus = z_q[63:32];
      else if (bus_if.Rout)     bus = sel_reg;
      else if (bus_if.BAout)    bus = (reg_idx == 4'd0) ? 32'h0 : sel_reg;
      else if (bus_if.Csignout) bus = c_sext;

      sum     = {1'b0, y_q} + {1'b0, bus};
      alu_res = 64'h0;
      if (bus_if.IncPC)    alu_res = {32'h0, bus + 32'd1};
      else if (bus_if.ADD) alu_res = {31'h0, sum};
   end

   always_comb begin
      r_d   = r_q;
      pc_d  = pc_q;
      ir_d  = ir_q;
      mar_d = mar_q;
      mdr_d = mdr_q;
      y_d   = y_q;
      z_d   = z_q;
      if (bus_if.Rin && (bus_if.Gra || bus_if.Grb || bus_if.Grc)) r_d[reg_idx] = bus;
      if (bus_if.PCin)  pc_d  = bus;
      if (bus_if.IRin)  ir_d  = bus;
      if (bus_if.MARin) mar_d = bus;
      if (bus_if.Yin)   y_d   = bus;
      if (bus_if.MDRin) mdr_d = (bus_if.Read || bus_if.MD_read) ? bus_if.Mdatain : bus;
      if (bus_if.Zlowin)  z_d[31:0]  = alu_res[31:0];
      if (bus_if.Zhighin) z_d[63:32] = alu_res[63:32];
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         r_q   <= '{default: 32'h0};
         pc_q  <= 32'h0;
         ir_q  <= 32'h0;
         mar_q <= 32'h0;
         mdr_q <= 32'h0;
         y_q   <= 32'h0;
         z_q   <= 64'h0;
      end else begin
         r_q   <= r_d;
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         mar_q <= mar_d;
         mdr_q <= mdr_d;
         y_q   <= y_d;
         z_q   <= z_d;
      end
   end

   assign bus_if.bus_out = bus;
   assign bus_if.mar_out = mar_q;
   assign bus_if.ir_out  = ir_q;
   assign bus_if.pc_out  = pc_q;
endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed micro-sequences plus random control words against a behavioural model.
module tb_data_path;
   typedef logic [21:0] ctl_t;
   localparam ctl_t PCIN     = 22'h1 << 0;
   localparam ctl_t IRIN     = 22'h1 << 1;
   localparam ctl_t MARIN    = 22'h1 << 2;
   localparam ctl_t MDRIN    = 22'h1 << 3;
   localparam ctl_t YIN      = 22'h1 << 4;
   localparam ctl_t ZLOWIN   = 22'h1 << 5;
   localparam ctl_t ZHIGHIN  = 22'h1 << 6;
   localparam ctl_t RIN      = 22'h1 << 7;
   localparam ctl_t PCOUT    = 22'h1 << 8;
   localparam ctl_t MDROUT   = 22'h1 << 9;
   localparam ctl_t ZLOWOUT  = 22'h1 << 10;
   localparam ctl_t ZHIGHOUT = 22'h1 << 11;
   localparam ctl_t ROUT     = 22'h1 << 12;
   localparam ctl_t BAOUT    = 22'h1 << 13;
   localparam ctl_t CSIGNOUT = 22'h1 << 14;
   localparam ctl_t GRA      = 22'h1 << 15;
   localparam ctl_t GRB      = 22'h1 << 16;
   localparam ctl_t GRC      = 22'h1 << 17;
   localparam ctl_t ADD      = 22'h1 << 18;
   localparam ctl_t INCPC    = 22'h1 << 19;
   localparam ctl_t READ     = 22'h1 << 20;
   localparam ctl_t MDREAD   = 22'h1 << 21;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   data_path_if dif ();
   data_path u_dut (.clock(clock), .clear(clear), .bus_if(dif.slave));

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] obs_bus;

   // Behavioural model of architectural state
   logic [31:0] m_r [16];
   logic [31:0] m_pc = 0, m_ir = 0, m_mar = 0, m_mdr = 0, m_y = 0;
   logic [63:0] m_z = 0;

   function automatic int m_sel(input ctl_t c);
      if (c & GRA) return int'(m_ir[26:23]);
      if (c & GRB) return int'(m_ir[22:19]);
      if (c & GRC) return int'(m_ir[18:15]);
      return 0;
   endfunction

   function automatic logic [31:0] m_bus(input ctl_t c);
      int s = m_sel(c);
      if (c & PCOUT)    return m_pc;
      if (c & MDROUT)   return m_mdr;
      if (c & ZLOWOUT)  return m_z[31:0];
      if (c & ZHIGHOUT) return m_z[63:32];
      if (c & ROUT)     return m_r[s];
      if (c & BAOUT)    return (s == 0) ? 32'h0 : m_r[s];
      if (c & CSIGNOUT) return m_ir[18] ? 32'(m_ir[18:0]) - 32'h80000 : 32'(m_ir[18:0]);
      return 32'h0;
   endfunction

   task automatic m_step(input ctl_t c, input logic [31:0] mdat, input logic clr);
      logic [31:0] b = m_bus(c);
      int          s = m_sel(c);
      logic [63:0] res = 64'h0;
      if (!clr) begin
         foreach (m_r[i]) m_r[i] = 32'h0;
         m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_z = 0;
         return;
      end
      if (c & INCPC)    res = 64'((b + 32'd1) % 64'h1_0000_0000);
      else if (c & ADD) res = 64'(m_y) + 64'(b);
      if ((c & RIN) && (c & (GRA | GRB | GRC))) m_r[s] = b;
      if (c & PCIN)  m_pc  = b;
      if (c & IRIN)  m_ir  = b;
      if (c & MARIN) m_mar = b;
      if (c & YIN)   m_y   = b;
      if (c & MDRIN) m_mdr = (c & (READ | MDREAD)) ? mdat : b;
      if (c & ZLOWIN)  m_z[31:0]  = res[31:0];
      if (c & ZHIGHIN) m_z[63:32] = res[63:32];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input ctl_t c, input logic [31:0] mdat);
      dif.Mdatain  = mdat;
      dif.PCin     = |(c & PCIN);     dif.IRin    = |(c & IRIN);
      dif.MARin    = |(c & MARIN);    dif.MDRin   = |(c & MDRIN);
      dif.Yin      = |(c & YIN);      dif.Zlowin  = |(c & ZLOWIN);
      dif.Zhighin  = |(c & ZHIGHIN);  dif.Rin     = |(c & RIN);
      dif.PCout    = |(c & PCOUT);    dif.MDRout  = |(c & MDROUT);
      dif.Zlowout  = |(c & ZLOWOUT);  dif.Zhighout = |(c & ZHIGHOUT);
      dif.Rout     = |(c & ROUT);     dif.BAout   = |(c & BAOUT);
      dif.Csignout = |(c & CSIGNOUT); dif.Gra     = |(c & GRA);
      dif.Grb      = |(c & GRB);      dif.Grc     = |(c & GRC);
      dif.ADD      = |(c & ADD);      dif.IncPC   = |(c & INCPC);
      dif.Read     = |(c & READ);     dif.MD_read = |(c & MDREAD);
   endtask

   // One clock: bus checked mid-cycle, visible registers checked just after the edge.
   task automatic cyc(input ctl_t c, input logic [31:0] mdat = 32'h0, input logic clr = 1'b1);
      drive(c, mdat);
      clear = clr;
      @(negedge clock);
      obs_bus = dif.bus_out;
      chk("bus", obs_bus, m_bus(c));
      @(posedge clock);
      m_step(c, mdat, clr);
      #1;
      chk("pc", dif.pc_out, m_pc);
      chk("ir", dif.ir_out, m_ir);
      chk("mar", dif.mar_out, m_mar);
   endtask

   initial begin
      foreach (m_r[i]) m_r[i] = 32'h0;
      clear = 1'b0;
      drive('0, 32'h0);
      #1;
      cyc('0, 32'h0, 1'b0);
      chk("rst_pc", dif.pc_out, 32'h0);

      // Fetch
      cyc(PCOUT | MARIN | INCPC | ZLOWIN);
      cyc(ZLOWOUT | PCIN | READ | MDRIN, 32'h0880_0000);
      cyc(MDROUT | IRIN);
      chk("fetch_mar", dif.mar_out, 32'h0);
      chk("fetch_pc", dif.pc_out, 32'h1);
      chk("fetch_ir", dif.ir_out, 32'h0880_0000);

      // R0 = 0x55 through Rb (=0), then ldi with R0 as base
      cyc(READ | MDRIN, 32'h55);
      cyc(MDROUT | GRB | RIN);
      cyc(GRB | ROUT);
      chk("rout_r0", obs_bus, 32'h55);
      cyc(GRB | BAOUT | YIN);
      chk("baout_r0", obs_bus, 32'h0);
      cyc(CSIGNOUT | ADD | ZLOWIN);
      cyc(ZLOWOUT | MARIN);
      chk("ldi_mar", dif.mar_out, 32'h0);
      cyc(READ | MDRIN, 32'h1234);
      cyc(MDROUT | GRA | RIN);
      cyc(GRA | ROUT);
      chk("ldi_r1", obs_bus, 32'h1234);

      // Ra=Rb=2, Rc=15, C=-1; R2=0x10 so the effective address is 0x0F
      cyc(READ | MDRIN, 32'h0917_FFFF);
      cyc(MDROUT | IRIN);
      cyc(MDREAD | MDRIN, 32'h10);
      cyc(MDROUT | GRA | RIN);
      cyc(GRB | BAOUT | YIN);
      chk("ba_r2", obs_bus, 32'h10);
      cyc(CSIGNOUT | ADD | ZLOWIN);
      chk("csign", obs_bus, 32'hFFFF_FFFF);
      cyc(ZLOWOUT | MARIN);
      chk("sext_mar", dif.mar_out, 32'h0F);

      // Carry out of the adder lands in Zhigh
      cyc(READ | MDRIN, 32'hFFFF_FFFF);
      cyc(MDROUT | YIN);
      cyc(READ | MDRIN, 32'h1);
      cyc(MDROUT | ADD | ZLOWIN | ZHIGHIN);
      cyc(ZLOWOUT);
      chk("carry_lo", obs_bus, 32'h0);
      cyc(ZHIGHOUT);
      chk("carry_hi", obs_bus, 32'h1);

      // IncPC wraps and wins over ADD (Y is still all ones)
      cyc(READ | MDRIN, 32'hFFFF_FFFF);
      cyc(MDROUT | INCPC | ADD | ZLOWIN | ZHIGHIN);
      cyc(ZLOWOUT);
      chk("inc_wrap_lo", obs_bus, 32'h0);
      cyc(ZHIGHOUT);
      chk("inc_wrap_hi", obs_bus, 32'h0);

      // MDR from bus when no read, bus idle, drive priority
      cyc(PCOUT | MDRIN, 32'hDEAD_BEEF);
      cyc(MDROUT);
      chk("mdr_from_bus", obs_bus, 32'h1);
      cyc('0);
      chk("bus_idle", obs_bus, 32'h0);
      cyc(PCOUT | MDROUT);
      chk("bus_prio", obs_bus, 32'h1);

      // Rin without any Gr select writes nothing, R0 included
      cyc(READ | MDRIN, 32'hDEAD_0000);
      cyc(MDROUT | RIN);
      cyc(ROUT);
      chk("rin_nogr_r0", obs_bus, 32'h55);
      cyc(GRA | ROUT);
      chk("rin_nogr_r2", obs_bus, 32'h10);

      // Random control words with occasional clears
      for (int i = 0; i < 400; i++) begin
         cyc(ctl_t'($urandom), $urandom, ($urandom_range(0, 23) != 0));
      end

      // Reset with every register nonzero and all load enables asserted
      cyc(READ | MDRIN, 32'hA5A5_A5A5);
      cyc(MDROUT | PCIN | IRIN | MARIN | YIN | GRA | RIN | ADD | ZLOWIN | ZHIGHIN);
      cyc(MDROUT | PCIN | IRIN | MARIN | MDRIN | YIN | ZLOWIN | ZHIGHIN | GRA | RIN | READ,
          32'h1111_1111, 1'b0);
      chk("rst_pc2", dif.pc_out, 32'h0);
      chk("rst_ir2", dif.ir_out, 32'h0);
      chk("rst_mar2", dif.mar_out, 32'h0);
      cyc(MDROUT | ADD | ZLOWIN);
      chk("rst_mdr", obs_bus, 32'h0);
      cyc(ZLOWOUT);
      chk("rst_y", obs_bus, 32'h0);
      cyc(GRA | ROUT);
      chk("rst_r0", obs_bus, 32'h0);
      cyc(ZHIGHOUT);
      chk("rst_zhi", obs_bus, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
